// File: rtl/uart_cpld_responder.sv
`timescale 1ns/1ps
// uart_cpld_responder
//
// Device side of the CPLD UART strobe interface. Answers active-low read and
// write strobes on a shared 8-bit bus, reports receive/transmit status flags,
// and serialises/deserialises 8N1 frames on txd/rxd.
//
// Parameters
//   CLK_FREQ        clock frequency in Hz
//   BAUD            line rate; DIV = CLK_FREQ / BAUD (truncated, >= 4)
//
// Ports
//   clk             system clock
//   rst             synchronous reset, active-low
//   uart_rdn        read strobe, active-low; bus shows rx_buf while low
//   uart_wrn        write strobe, active-low; falling edge latches the bus
//   uart_data       shared bidirectional data bus
//   uart_dataready  receive buffer holds an unread byte
//   uart_tbre       transmit holding register empty
//   uart_tsre       transmit shifter empty, line idle
//   txd             serial out, idle high
//   rxd             serial in, asynchronous
//
// Build option
//   UART_STOP_CHECK_EN  when defined, a stop bit sampled low is a framing
//                       error: the byte is dropped and the receiver waits for
//                       the line to return high before looking for a new
//                       start bit. When undefined the stop bit is ignored.
//
// TX FSM
//   state | meaning
//   IDLE  | line high, waiting for a byte in tx_hold
//   START | driving start bit (low) for DIV cycles
//   DATA  | driving 8 data bits LSB first, DIV cycles each
//   STOP  | driving stop bit (high) for DIV cycles, then reload or idle
//
// RX FSM
//   state | meaning
//   IDLE  | waiting for synchronised rxd low
//   START | half-bit wait, re-check start bit to reject glitches
//   DATA  | sampling 8 data bits at bit centres
//   STOP  | sampling stop bit, delivering byte to rx_buf

module uart_cpld_responder #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rdn,
  input  logic       uart_wrn,
  inout  wire  [7:0] uart_data,
  output logic       uart_dataready,
  output logic       uart_tbre,
  output logic       uart_tsre,
  output logic       txd,
  input  logic       rxd
);

  localparam int DIV   = CLK_FREQ / BAUD;
  localparam int HALF  = DIV / 2;
  localparam int CNT_W = $clog2(DIV);

  localparam logic [CNT_W-1:0] DIV_M1  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // ---------------------------------------------------------------------
  // Bus and strobe edge detection
  // ---------------------------------------------------------------------
  logic [7:0] rx_buf;
  logic       wrn_q;
  logic       rdn_q;
  logic       wr_fall;
  logic       rd_rise;

  assign uart_data = (!uart_rdn) ? rx_buf : 8'hzz;

  assign wr_fall = wrn_q & ~uart_wrn;
  assign rd_rise = ~rdn_q & uart_rdn;

  // ---------------------------------------------------------------------
  // Transmit path
  // ---------------------------------------------------------------------
  logic [1:0]       tx_state;
  logic [CNT_W-1:0] tx_cnt;
  logic [2:0]       tx_bit;
  logic [7:0]       tx_shift;
  logic [7:0]       tx_hold;
  logic             tx_load;
  logic             wr_accept;

  // A load empties the holding register in the same cycle, so a write that
  // coincides with a load is accepted and refills it behind the load.
  always_comb begin
    tx_load = 1'b0;
    if (!uart_tbre) begin
      if (tx_state == ST_IDLE)
        tx_load = 1'b1;
      else if ((tx_state == ST_STOP) && (tx_cnt == '0))
        tx_load = 1'b1;
    end
  end

  assign wr_accept = wr_fall & (uart_tbre | tx_load);

  always_ff @(posedge clk) begin
    if (!rst) begin
      wrn_q     <= 1'b1;
      tx_hold   <= 8'h00;
      uart_tbre <= 1'b1;
      uart_tsre <= 1'b1;
      txd       <= 1'b1;
      tx_state  <= ST_IDLE;
      tx_cnt    <= '0;
      tx_bit    <= 3'd0;
      tx_shift  <= 8'h00;
    end else begin
      wrn_q <= uart_wrn;

      if (wr_accept)
        tx_hold <= uart_data;

      if (wr_accept)
        uart_tbre <= 1'b0;
      else if (tx_load)
        uart_tbre <= 1'b1;

      case (tx_state)
        ST_IDLE: begin
          if (tx_load) begin
            tx_shift  <= tx_hold;
            txd       <= 1'b0;
            uart_tsre <= 1'b0;
            tx_cnt    <= DIV_M1;
            tx_state  <= ST_START;
          end
        end

        ST_START: begin
          if (tx_cnt == '0) begin
            tx_cnt   <= DIV_M1;
            tx_bit   <= 3'd0;
            txd      <= tx_shift[0];
            tx_state <= ST_DATA;
          end else begin
            tx_cnt <= tx_cnt - CNT_ONE;
          end
        end

        ST_DATA: begin
          if (tx_cnt == '0) begin
            tx_cnt <= DIV_M1;
            if (tx_bit == 3'd7) begin
              txd      <= 1'b1;
              tx_state <= ST_STOP;
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              tx_shift <= {1'b0, tx_shift[7:1]};
              txd      <= tx_shift[1];
            end
          end else begin
            tx_cnt <= tx_cnt - CNT_ONE;
          end
        end

        ST_STOP: begin
          if (tx_cnt == '0) begin
            if (tx_load) begin
              // back-to-back: next start bit follows the stop bit directly
              tx_shift <= tx_hold;
              txd      <= 1'b0;
              tx_cnt   <= DIV_M1;
              tx_state <= ST_START;
            end else begin
              uart_tsre <= 1'b1;
              tx_state  <= ST_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt - CNT_ONE;
          end
        end

        default: tx_state <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Receive path
  // ---------------------------------------------------------------------
  logic             rxd_meta;
  logic             rxd_sync;
  logic [1:0]       rx_state;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shift;
  logic             rx_done;

`ifdef UART_STOP_CHECK_EN
  logic rx_ferr;

  assign rx_done = (rx_state == ST_STOP) && !rx_ferr && (rx_cnt == '0) && rxd_sync;
`else
  assign rx_done = (rx_state == ST_STOP) && (rx_cnt == '0);
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_sync <= rxd_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rdn_q          <= 1'b1;
      rx_buf         <= 8'h00;
      uart_dataready <= 1'b0;
    end else begin
      rdn_q <= uart_rdn;

      if (rx_done)
        rx_buf <= rx_shift;

      // a completing byte beats a simultaneous read acknowledge
      if (rx_done)
        uart_dataready <= 1'b1;
      else if (rd_rise)
        uart_dataready <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_state <= ST_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= 3'd0;
      rx_shift <= 8'h00;
`ifdef UART_STOP_CHECK_EN
      rx_ferr  <= 1'b0;
`endif
    end else begin
      case (rx_state)
        ST_IDLE: begin
          if (!rxd_sync) begin
            rx_cnt   <= HALF_M1;
            rx_state <= ST_START;
          end
        end

        ST_START: begin
          if (rx_cnt == '0) begin
            if (rxd_sync) begin
              rx_state <= ST_IDLE;
            end else begin
              rx_cnt   <= DIV_M1;
              rx_bit   <= 3'd0;
              rx_state <= ST_DATA;
            end
          end else begin
            rx_cnt <= rx_cnt - CNT_ONE;
          end
        end

        ST_DATA: begin
          if (rx_cnt == '0) begin
            rx_cnt   <= DIV_M1;
            rx_shift <= {rxd_sync, rx_shift[7:1]};
            if (rx_bit == 3'd7)
              rx_state <= ST_STOP;
            else
              rx_bit <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt - CNT_ONE;
          end
        end

        ST_STOP: begin
`ifdef UART_STOP_CHECK_EN
          // after a framing error, hold here until the line goes idle so a
          // low stop bit is not mistaken for the next start bit
          if (rx_ferr) begin
            if (rxd_sync) begin
              rx_ferr  <= 1'b0;
              rx_state <= ST_IDLE;
            end
          end else if (rx_cnt == '0) begin
            if (rxd_sync)
              rx_state <= ST_IDLE;
            else
              rx_ferr <= 1'b1;
          end else begin
            rx_cnt <= rx_cnt - CNT_ONE;
          end
`else
          if (rx_cnt == '0)
            rx_state <= ST_IDLE;
          else
            rx_cnt <= rx_cnt - CNT_ONE;
`endif
        end

        default: rx_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cpld_responder.sv
`timescale 1ns/1ps
// Directed bench for uart_cpld_responder at DIV = 8 (800 Hz / 100 baud).
// The shared bus carries pull-ups, so an undriven bus reads 8'hff.

module tb_uart_cpld_responder;

  localparam int DIV = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_rdn;
  logic       uart_wrn;
  wire  [7:0] uart_data;
  logic       uart_dataready;
  logic       uart_tbre;
  logic       uart_tsre;
  logic       txd;
  logic       rxd;

  logic [7:0] tb_data;
  logic       tb_drive;

  int tests = 0;
  int fails = 0;

  assign uart_data = tb_drive ? tb_data : 8'hzz;

  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (uart_data[i]);
  end

  uart_cpld_responder #(
    .CLK_FREQ(800),
    .BAUD    (100)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .uart_rdn      (uart_rdn),
    .uart_wrn      (uart_wrn),
    .uart_data     (uart_data),
    .uart_dataready(uart_dataready),
    .uart_tbre     (uart_tbre),
    .uart_tsre     (uart_tsre),
    .txd           (txd),
    .rxd           (rxd)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [7:0] d);
    tb_data  = d;
    tb_drive = 1'b1;
    uart_wrn = 1'b0;
    tick();
    uart_wrn = 1'b1;
    tb_drive = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    rxd = 1'b0;
    repeat (DIV) tick();
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (DIV) tick();
    end
    rxd = stop_bit;
    repeat (DIV) tick();
    rxd = 1'b1;
  endtask

  task automatic do_read(input string tag, input logic [7:0] exp);
    uart_rdn = 1'b0;
    #1;
    check(tag, uart_data, exp);
    tick();
    uart_rdn = 1'b1;
    tick();
    tick();
  endtask

  logic [9:0]  fa5;
  logic [19:0] f2;

  initial begin
    rst      = 1'b0;
    uart_rdn = 1'b1;
    uart_wrn = 1'b1;
    rxd      = 1'b1;
    tb_drive = 1'b0;
    tb_data  = 8'h00;
    fa5      = {1'b1, 8'hA5, 1'b0};
    f2       = {1'b1, 8'h0F, 1'b0, 1'b1, 8'h55, 1'b0};

    // reset
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("rst_txd", txd, 1);
    check("rst_tbre", uart_tbre, 1);
    check("rst_tsre", uart_tsre, 1);
    check("rst_dready", uart_dataready, 0);
    check("rst_bus_z", uart_data, 8'hff);
    uart_rdn = 1'b0;
    #1;
    check("rst_rxbuf", uart_data, 8'h00);
    uart_rdn = 1'b1;
    tick();

    // single write 0xA5
    do_write(8'hA5);
    check("wr_tbre_low", uart_tbre, 0);
    check("wr_txd_idle", txd, 1);
    check("wr_tsre_idle", uart_tsre, 1);
    tick();
    check("ld_tbre", uart_tbre, 1);
    check("ld_tsre", uart_tsre, 0);
    check("ld_txd", txd, 0);
    for (int k = 0; k < 10; k++) begin
      repeat (4) tick();
      check("a5_bit", txd, fa5[k]);
      repeat (3) tick();
      if (k == 9) check("a5_tsre_last", uart_tsre, 0);
      tick();
    end
    check("a5_tsre_end", uart_tsre, 1);
    check("a5_txd_end", txd, 1);
    check("a5_tbre_end", uart_tbre, 1);
    repeat (5) tick();

    // back-to-back 0x55, 0x0F; third write 0x99 dropped
    do_write(8'h55);
    tick();
    for (int c = 1; c <= 160; c++) begin
      if (c == 10) begin
        tb_data = 8'h0F; tb_drive = 1'b1; uart_wrn = 1'b0;
      end
      if (c == 11) begin
        uart_wrn = 1'b1; tb_drive = 1'b0;
        check("b2b_tbre_wr2", uart_tbre, 0);
      end
      if (c == 20) begin
        tb_data = 8'h99; tb_drive = 1'b1; uart_wrn = 1'b0;
      end
      if (c == 21) begin
        uart_wrn = 1'b1; tb_drive = 1'b0;
        check("b2b_tbre_drop", uart_tbre, 0);
      end
      if (c == 81) begin
        check("b2b_reload_tbre", uart_tbre, 1);
        check("b2b_reload_txd", txd, 0);
      end
      if ((c - 1) % 8 == 4) begin
        check("b2b_bit", txd, f2[(c-1)/8]);
        check("b2b_tsre", uart_tsre, 0);
      end
      tick();
    end
    check("b2b_tsre_end", uart_tsre, 1);
    check("b2b_txd_end", txd, 1);
    check("b2b_tbre_end", uart_tbre, 1);
    repeat (5) tick();

    // receive 0x3C
    check("rx_pre_dready", uart_dataready, 0);
    send_frame(8'h3C, 1'b1);
    check("rx_dready", uart_dataready, 1);
    uart_rdn = 1'b0;
    tick();
    check("rx_dready_during_read", uart_dataready, 1);
    uart_rdn = 1'b1;
    tick();
    do_read("rx_data", 8'h3C);
    check("rx_dready_clr", uart_dataready, 0);
    do_read("rx_buf_kept", 8'h3C);

    // glitch
    rxd = 1'b0;
    repeat (2) tick();
    rxd = 1'b1;
    repeat (100) tick();
    check("glitch_no_byte", uart_dataready, 0);

    // overrun
    send_frame(8'h11, 1'b1);
    check("ovr_first", uart_dataready, 1);
    send_frame(8'h22, 1'b1);
    repeat (4) tick();
    check("ovr_dready", uart_dataready, 1);
    do_read("ovr_data", 8'h22);
    check("ovr_clr", uart_dataready, 0);

    // framing error: stop bit low
    send_frame(8'h77, 1'b0);
    repeat (6) tick();
`ifdef UART_STOP_CHECK_EN
    check("ferr_dready", uart_dataready, 0);
    do_read("ferr_buf_kept", 8'h22);
`else
    check("ferr_dready", uart_dataready, 1);
    do_read("ferr_data", 8'h77);
`endif
    repeat (10) tick();

    // reset mid-frame (TX and RX both busy)
    send_frame(8'h5A, 1'b1);
    check("pre_rst_dready", uart_dataready, 1);
    do_write(8'hC3);
    rxd = 1'b0;
    repeat (12) tick();
    check("pre_rst_tsre", uart_tsre, 0);
    rst = 1'b0;
    rxd = 1'b1;
    tick();
    check("mid_rst_txd", txd, 1);
    check("mid_rst_tsre", uart_tsre, 1);
    check("mid_rst_tbre", uart_tbre, 1);
    check("mid_rst_dready", uart_dataready, 0);
    rst = 1'b1;
    repeat (100) tick();
    check("post_rst_txd", txd, 1);
    check("post_rst_dready", uart_dataready, 0);
    do_read("post_rst_rxbuf", 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
